// File: rtl/button_input_pkg.sv
// Status-word layout shared by the button peripheral and anything decoding its register.
package button_input_pkg;

    localparam int LEVEL_LSB   = 0;
    localparam int PRESS_LSB   = 8;
    localparam int RELEASE_LSB = 16;
    localparam int IRQ_EN_BIT  = 24;

    typedef struct packed {
        logic [30-IRQ_EN_BIT:0]             rsvd;
        logic                               irq_en;
        logic [IRQ_EN_BIT-RELEASE_LSB-1:0]  rel;
        logic [RELEASE_LSB-PRESS_LSB-1:0]   press;
        logic [PRESS_LSB-LEVEL_LSB-1:0]     level;
    } status_t;

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-flop synchronizer, run-length debounce; rise/fall pulse on the edge the level is accepted.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles; no backpressure.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any cycle where the synchronized input agrees with the accepted level restarts the run.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            accept   = 1'b1;
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign level = stable_q;
    assign rise  = accept &  sync2_q;
    assign fall  = accept & ~sync2_q;

endmodule

// File: rtl/button_input.sv
// Push-button status register: debounced levels, sticky W1C press/release flags, press interrupt.
// Reads are combinational and side-effect free; a flag set on the same edge as its clear stays set.
module button_input
    import button_input_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StatusRead,
    input  logic             StatusWrite,
    input  logic [31:0]      Write_data,
    output logic [31:0]      Read_data,
    input  logic [N_BTN-1:0] btn_raw,
    output logic             irq
);

    logic [N_BTN-1:0] level, rise, fall;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] rel_q, rel_d;
    logic             irq_en_q, irq_en_d;
    logic [N_BTN-1:0] clr_press, clr_rel;
    status_t          status;
    logic             unused_wdata;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn_raw[i]),
            .level  (level[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    assign clr_press    = StatusWrite ? Write_data[PRESS_LSB +: N_BTN]   : '0;
    assign clr_rel      = StatusWrite ? Write_data[RELEASE_LSB +: N_BTN] : '0;
    assign unused_wdata = ^Write_data;

    // Event OR-ed in after the clear so a coincident set wins.
    always_comb begin
        press_d  = (press_q & ~clr_press) | rise;
        rel_d    = (rel_q   & ~clr_rel)   | fall;
        irq_en_d = StatusWrite ? Write_data[IRQ_EN_BIT] : irq_en_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_q  <= '0;
            rel_q    <= '0;
            irq_en_q <= 1'b0;
        end else begin
            press_q  <= press_d;
            rel_q    <= rel_d;
            irq_en_q <= irq_en_d;
        end
    end

    always_comb begin
        status                   = '0;
        status.level[N_BTN-1:0]  = level;
        status.press[N_BTN-1:0]  = press_q;
        status.rel[N_BTN-1:0]    = rel_q;
        status.irq_en            = irq_en_q;
        Read_data                = StatusRead ? status : 32'h0;
    end

    assign irq = irq_en_q & (|press_q);

endmodule

// File: tb/tb_button_input.sv
// Scoreboarded random/directed bench for button_input with a sliding-window debounce model.
module tb_button_input;

    localparam int NB = 4;
    localparam int D  = 4;

    logic          clk = 1'b1;
    logic          reset = 1'b1;
    logic          StatusRead = 1'b0;
    logic          StatusWrite = 1'b0;
    logic [31:0]   Write_data = 32'h0;
    logic [31:0]   Read_data;
    logic [NB-1:0] btn_raw = '0;
    logic          irq;

    button_input #(
        .N_BTN(NB),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .StatusRead (StatusRead),
        .StatusWrite(StatusWrite),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .btn_raw    (btn_raw),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // win[0] is the raw value sampled by the latest edge; win[k] is k edges older.
    logic [NB-1:0] win [D+2];
    logic [NB-1:0] m_lvl, m_prs, m_rel;
    logic          m_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    function automatic logic [31:0] m_status();
        return {7'b0, m_en, 4'b0, m_rel, 4'b0, m_prs, 4'b0, m_lvl};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < D + 2; k++) win[k] = '0;
        m_lvl = '0;
        m_prs = '0;
        m_rel = '0;
        m_en  = 1'b0;
    endtask

    // A level is accepted once the last D synchronized samples all disagree with it.
    task automatic model_edge(input logic [NB-1:0] raw, input logic wr, input logic [31:0] wd);
        logic [NB-1:0] ev_r, ev_f, c_p, c_r;
        logic          all_diff;
        for (int k = D + 1; k > 0; k--) win[k] = win[k-1];
        win[0] = raw;
        ev_r = '0;
        ev_f = '0;
        for (int b = 0; b < NB; b++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= D + 1; k++)
                if (win[k][b] == m_lvl[b]) all_diff = 1'b0;
            if (all_diff) begin
                if (m_lvl[b]) ev_f[b] = 1'b1;
                else          ev_r[b] = 1'b1;
            end
        end
        m_lvl = m_lvl ^ (ev_r | ev_f);
        c_p   = wr ? wd[11:8]  : '0;
        c_r   = wr ? wd[19:16] : '0;
        m_prs = (m_prs & ~c_p) | ev_r;
        m_rel = (m_rel & ~c_r) | ev_f;
        if (wr) m_en = wd[24];
    endtask

    task automatic cyc(input logic [NB-1:0] raw, input logic rd, input logic wr,
                       input logic [31:0] wd, input logic rst);
        exp_t e;
        btn_raw     = raw;
        StatusRead  = rd;
        StatusWrite = wr;
        Write_data  = wd;
        reset       = rst;
        if (rst) model_reset();
        e.rd  = rd ? m_status() : 32'h0;
        e.irq = m_en & (|m_prs);
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst) model_edge(raw, wr, wd);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] expv, input logic exp_irq);
        #1;
        chk({name, "_rd"}, Read_data, expv);
        chk({name, "_irq"}, {31'b0, irq}, {31'b0, exp_irq});
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_rd", Read_data, e.rd);
            chk("sb_irq", {31'b0, irq}, {31'b0, e.irq});
        end
    end

    initial begin
        logic [NB-1:0] r;
        model_reset();

        repeat (3) cyc(4'b0000, 1'b1, 1'b0, 32'h0, 1'b1);
        rd_chk("reset", 32'h0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, 32'h0, 1'b0);

        repeat (5) cyc(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
        rd_chk("press_e5", 32'h0, 1'b0);
        cyc(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
        rd_chk("press_e6", 32'h0000_0101, 1'b0);

        repeat (3) cyc(4'b0011, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (8) cyc(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
        rd_chk("glitch", 32'h0000_0101, 1'b0);
        repeat (5) cyc(4'b0011, 1'b1, 1'b0, 32'h0, 1'b0);
        rd_chk("hold_e5", 32'h0000_0101, 1'b0);
        cyc(4'b0011, 1'b1, 1'b0, 32'h0, 1'b0);
        rd_chk("hold_e6", 32'h0000_0303, 1'b0);

        cyc(4'b0011, 1'b1, 1'b1, 32'h0000_0300, 1'b0);
        cyc(4'b0011, 1'b1, 1'b1, 32'h0100_0000, 1'b0);
        rd_chk("irq_en", 32'h0100_0003, 1'b0);
        repeat (6) cyc(4'b0111, 1'b1, 1'b0, 32'h0, 1'b0);
        rd_chk("irq_on", 32'h0100_0407, 1'b1);
        cyc(4'b0111, 1'b1, 1'b1, 32'h0, 1'b0);
        rd_chk("irq_dis", 32'h0000_0407, 1'b0);
        cyc(4'b0111, 1'b1, 1'b1, 32'h0100_0400, 1'b0);
        rd_chk("irq_clr", 32'h0100_0007, 1'b0);

        repeat (5) cyc(4'b0110, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(4'b0110, 1'b1, 1'b1, 32'h0101_0000, 1'b0);
        rd_chk("set_wins", 32'h0101_0006, 1'b0);

        repeat (4) cyc(4'b1110, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(4'b1110, 1'b1, 1'b0, 32'h0, 1'b1);
        rd_chk("mid_reset", 32'h0, 1'b0);
        cyc(4'b1110, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (5) cyc(4'b1110, 1'b1, 1'b0, 32'h0, 1'b0);
        rd_chk("post_rst_e5", 32'h0, 1'b0);
        cyc(4'b1110, 1'b1, 1'b0, 32'h0, 1'b0);
        rd_chk("post_rst_e6", 32'h0000_0E0E, 1'b0);

        r = 4'b1110;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 4) == 0) r[$urandom_range(0, NB-1)] ^= 1'b1;
            cyc(r, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom,
                $urandom_range(0, 199) == 0);
        end
        cyc(r, 1'b1, 1'b0, 32'h0, 1'b0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
